// File: rtl/bsearch_engine_pkg.sv
// Shared constants for the binary-search engine: FSM state encoding and default widths.
// Pure declarations, no logic and no latency of its own.
// No flow control here; it is imported by the engine and its interface.
package bsearch_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    // CHECK is the loop test; PROBE issues a read, WAIT holds it until the response arrives
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        PROBE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bsearch_engine_if.sv
// Bundle for the search request/result handshake and the table read port.
// Wiring only, no latency; optional probe_cnt appears when BSEARCH_PROBE_CNT_EN is defined.
// Read port stalls on rd_req until rd_valid; a start is accepted only while the engine is idle.
interface bsearch_if
    import bsearch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic [DATA_W-1:0] key;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   result_idx;
    logic              found;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
`ifdef BSEARCH_PROBE_CNT_EN
    logic [ADDR_W:0]   probe_cnt;
`endif

    // Engine side
    modport slave (
        input  start, key, len, rd_valid, rd_data,
        output busy, done, result_idx, found, rd_req, rd_addr
`ifdef BSEARCH_PROBE_CNT_EN
        , output probe_cnt
`endif
    );

    // Requester / table-memory side
    modport master (
        output start, key, len, rd_valid, rd_data,
        input  busy, done, result_idx, found, rd_req, rd_addr
`ifdef BSEARCH_PROBE_CNT_EN
        , input probe_cnt
`endif
    );

endinterface

// File: rtl/bsearch_engine.sv
// Lower-bound binary search over an external sorted table; optional probe counter under BSEARCH_PROBE_CNT_EN.
// Latency: 2 cycles for len=0, otherwise about 3 cycles per probe plus read latency, at most ceil(log2(len+1)) probes.
// Backpressure: holds rd_req/rd_addr indefinitely until rd_valid; start is ignored unless idle.
module bsearch_engine
    import bsearch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic       clk,
    input  logic       rst_n,
    bsearch_if.slave   bus
);

    state_t            r_state;
    logic [ADDR_W:0]   r_lo;
    logic [ADDR_W:0]   r_hi;
    logic [ADDR_W:0]   r_mid;
    logic [DATA_W-1:0] r_key;
    logic              r_hit;
    logic              r_busy;
    logic              r_done;
    logic              r_found;
    logic [ADDR_W:0]   r_result_idx;
    logic              r_rd_req;
    logic [ADDR_W-1:0] r_rd_addr;
`ifdef BSEARCH_PROBE_CNT_EN
    logic [ADDR_W:0]   r_probe_cnt;
`endif

    // lo+hi can reach 2^(ADDR_W+1), so the sum carries one extra bit before halving
    logic [ADDR_W+1:0] w_sum;
    logic [ADDR_W:0]   w_mid;

    assign w_sum = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid = (ADDR_W+1)'(w_sum >> 1);

    // Search FSM and datapath; every output is a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_lo         <= '0;
            r_hi         <= '0;
            r_mid        <= '0;
            r_key        <= '0;
            r_hit        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_result_idx <= '0;
            r_rd_req     <= 1'b0;
            r_rd_addr    <= '0;
`ifdef BSEARCH_PROBE_CNT_EN
            r_probe_cnt  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_lo    <= '0;
                        r_hi    <= bus.len;
                        r_key   <= bus.key;
                        r_found <= 1'b0;
                        r_hit   <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef BSEARCH_PROBE_CNT_EN
                        r_probe_cnt <= '0;
`endif
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (r_lo < r_hi) begin
                        r_mid   <= w_mid;
                        r_state <= PROBE;
                    end else begin
                        // busy drops in the same cycle done is high
                        r_result_idx <= r_lo;
                        r_found      <= r_hit;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= DONE;
                    end
                end
                PROBE: begin
                    // mid < hi <= 2^ADDR_W, so the low ADDR_W bits are the full address
                    r_rd_req  <= 1'b1;
                    r_rd_addr <= r_mid[ADDR_W-1:0];
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (bus.rd_valid) begin
                        r_rd_req <= 1'b0;
                        if (bus.rd_data < r_key) begin
                            r_lo <= r_mid + {{ADDR_W{1'b0}}, 1'b1};
                        end else begin
                            r_hi <= r_mid;
                        end
                        if (bus.rd_data == r_key) begin
                            r_hit <= 1'b1;
                        end
`ifdef BSEARCH_PROBE_CNT_EN
                        r_probe_cnt <= r_probe_cnt + {{ADDR_W{1'b0}}, 1'b1};
`endif
                        r_state <= CHECK;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.found      = r_found;
    assign bus.result_idx = r_result_idx;
    assign bus.rd_req     = r_rd_req;
    assign bus.rd_addr    = r_rd_addr;
`ifdef BSEARCH_PROBE_CNT_EN
    assign bus.probe_cnt  = r_probe_cnt;
`endif

endmodule

// File: tb/tb_bsearch_engine.sv
// Directed bench for bsearch_engine: scoreboard queue filled at start, popped by a done monitor.
// A table-memory model answers reads after a programmable delay and counts requests/responses.
// Build with BSEARCH_PROBE_CNT_EN defined to also check the probe counter.
module tb_bsearch_engine;
    import bsearch_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;

    typedef struct {
        int idx;
        int fnd;
        int bound;
        int vld_base;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    logic [DW-1:0] mem [0:255];
    int mem_delay = 0;
    int req_total = 0;
    int vld_total = 0;

    bsearch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    bsearch_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Table memory model: answers a held request after mem_delay cycles, checks address stability
    initial begin : mem_model
        int cnt;
        logic [AW-1:0] saved;
        cnt = 0;
        saved = '0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.rd_valid = 1'b0;
                cnt = 0;
            end else if (bus.rd_valid) begin
                bus.rd_valid = 1'b0;
                cnt = 0;
            end else if (bus.rd_req) begin
                if (cnt == 0) begin
                    req_total++;
                    saved = bus.rd_addr;
                end else begin
                    chk("rd_addr_stable", int'(bus.rd_addr), int'(saved));
                end
                if (cnt >= mem_delay) begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = mem[bus.rd_addr];
                    vld_total++;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Done monitor: every done must match the oldest expected result
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result_idx", int'(bus.result_idx), e.idx);
                    chk("found", int'(bus.found), e.fnd);
                    chk("probe_bound_ok", int'((vld_total - e.vld_base) <= e.bound), 1);
`ifdef BSEARCH_PROBE_CNT_EN
                    chk("probe_cnt", int'(bus.probe_cnt), vld_total - e.vld_base);
`endif
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            if (!bus.busy && !bus.done) return;
            @(negedge clk);
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        chk("wait_done_timeout", 1, 0);
    endtask

    // Issue one start pulse at a negedge; push the expected result when scored
    task automatic issue(input int k, input int l, input int exp_idx, input int exp_fnd,
                         input int bound, input bit score);
        exp_t e;
        wait_idle();
        bus.start = 1'b1;
        bus.key   = DW'(k);
        bus.len   = (AW+1)'(l);
        if (score) begin
            e.idx = exp_idx;
            e.fnd = exp_fnd;
            e.bound = bound;
            e.vld_base = vld_total;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic search(input int k, input int l, input int exp_idx, input int exp_fnd,
                          input int bound);
        issue(k, l, exp_idx, exp_fnd, bound, 1'b1);
        wait_done();
    endtask

    initial begin : stim
        int base_req;
        bit seen;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.key   = '0;
        bus.len   = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        mem[0] = 8'd3; mem[1] = 8'd5; mem[2] = 8'd5; mem[3] = 8'd9; mem[4] = 8'd12;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_rd_req", int'(bus.rd_req), 0);
        chk("rst_rd_addr", int'(bus.rd_addr), 0);
        chk("rst_result_idx", int'(bus.result_idx), 0);
        chk("rst_found", int'(bus.found), 0);
`ifdef BSEARCH_PROBE_CNT_EN
        chk("rst_probe_cnt", int'(bus.probe_cnt), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Table [3,5,5,9,12]
        search(5,  5, 1, 1, 3);
        search(6,  5, 3, 0, 3);
        search(20, 5, 5, 0, 3);
        search(0,  5, 0, 0, 3);
        search(12, 5, 4, 1, 3);

        // Empty table: no read, done two cycles after start
        wait_idle();
        base_req = req_total;
        issue(7, 0, 0, 0, 0, 1'b1);
        chk("len0_done_c1", int'(bus.done), 0);
        @(negedge clk);
        chk("len0_done_c2", int'(bus.done), 1);
        chk("len0_no_rd_req", req_total - base_req, 0);

        // Slow memory with a stray start while busy
        mem_delay = 5;
        issue(9, 5, 3, 1, 3, 1'b1);
        repeat (6) @(negedge clk);
        chk("busy_mid_search", int'(bus.busy), 1);
        bus.start = 1'b1;
        bus.key   = 8'd3;
        bus.len   = 9'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        // Reset while waiting on a read: search abandoned, no done
        mem_delay = 50;
        issue(5, 5, 0, 0, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.rd_req) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rd_req_before_reset", int'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_req", int'(bus.rd_req), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_done", int'(bus.done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        mem_delay = 0;
        search(5, 5, 1, 1, 3);

        // Full 256-entry table of identical values, immediate and delayed responses
        for (int i = 0; i < 256; i++) mem[i] = 8'd200;
        search(200, 256, 0, 1, 9);
        mem_delay = 5;
        search(200, 256, 0, 1, 9);
        mem_delay = 0;
        search(201, 256, 256, 0, 9);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
